bridge_dataslot_lookup: RTL and testbench
=========================================

Name: bridge_dataslot_lookup

Overview:
- Owns the 64-word dataslot table that the APF bridge writes (32 slots × {id word, size word}).
- Shares the table's single RAM port between the bridge (always wins) and an internal scan FSM.
- Core logic submits a 16-bit slot ID; the FSM scans slots in index order and returns the size and index of the first match, or a not-found result.

Parameters:
- NUM_SLOTS, 32, number of slots; power of two, 2..32; table depth is 2*NUM_SLOTS words.

Ports:
- clk  in  1  single clock for bridge, RAM and FSM.
- reset_n  in  1  asynchronous, active-low reset.
- bridge_addr  in  32  byte address; word index = bridge_addr[log2(2*NUM_SLOTS)+1:2]; upper bits ignored.
- bridge_wr  in  1  write strobe.
- bridge_rd  in  1  read strobe.
- bridge_wr_data  in  32  write data.
- bridge_rd_data  out  32  registered RAM read data.
- req_valid  in  1  lookup request.
- req_ready  out  1  high only in IDLE.
- req_id  in  16  slot ID to find.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_found  out  1  match found.
- rsp_index  out  5  matching slot index.
- rsp_size  out  32  size word of the matching slot.

Behaviour:
- RAM:
  - One port, registered read, no read reset.
  - Each cycle the selected address is read into the data register; data is available the next cycle.
  - When bridge_wr is high, the same cycle also writes.
- Port ownership:
  - Bridge owns the port whenever bridge_wr | bridge_rd.
  - Otherwise the FSM address drives it.
  - bridge_rd_data always equals the shared data register, so a bridge read at cycle t returns data at t+1.
- Entry layout:
  - Word 2k: slot ID in [15:0]; [31:16] ignored.
  - Word 2k+1: size.
- Valid bitmap (NUM_SLOTS bits):
  - Reset to 0.
  - Bit k is set on any bridge write to word 2k.
  - Never cleared except by reset.
- Accept: req_valid & req_ready; req_id is latched, idx=0, state goes to SCAN.
- FSM states: IDLE, SCAN, WAIT_ID, RD_SIZE, WAIT_SIZE, DONE.
- SCAN:
  - If a bridge access is active: hold; no change.
  - Else if valid[idx]=0: idx+1, or DONE with found=0 if idx is the last slot.
  - Else: drive address 2*idx, go to WAIT_ID.
- WAIT_ID: compare data[15:0] with the latched ID.
  - Match: go to RD_SIZE.
  - No match: idx+1 → SCAN, or DONE with found=0 if idx is the last slot.
- RD_SIZE:
  - If a bridge access is active: hold.
  - Else: drive address 2*idx+1, go to WAIT_SIZE.
- WAIT_SIZE: capture data into rsp_size, rsp_found=1, rsp_index=idx, go to DONE.
- DONE:
  - rsp_valid=1 for exactly this cycle, then IDLE.
  - On not-found: rsp_found=0, rsp_index=0, rsp_size=0.
- Bridge activity during WAIT_* is allowed; the captured data is from the prior-cycle FSM read.
- Output hold: rsp_found, rsp_index and rsp_size hold until the next DONE.
- Ordering: the lowest matching index wins (duplicate IDs).
- Reset values: rsp_valid=0, rsp_found=0, rsp_index=0, rsp_size=0, bridge_rd_data=0, state IDLE, so req_ready=1 after reset release.
- Reset mid-scan: aborts with no response and clears the bitmap; RAM contents are retained but unreachable until rewritten.
- Coherence: scans see whatever the RAM holds at each read; a concurrent bridge write to a slot is neither detected nor retried.
- Latency, no bridge traffic, accept at cycle 0:
  - Match at slot 0: rsp_valid at cycle 5, req_ready at cycle 6.
  - Empty table: rsp_valid at cycle NUM_SLOTS+1.
  - Cost per slot: invalid 1 cycle, valid-mismatch 2 cycles, match +2 cycles.
  - Each cycle of bridge access during SCAN or RD_SIZE adds 1 cycle.

Test Plan:
- Bridge write 0x0000_0007 to byte 0x00 and 0x0000_1000 to byte 0x04; read byte 0x04 → bridge_rd_data=0x0000_1000 one cycle after the strobe. Then lookup ID 7 → rsp_valid at cycle 5, found=1, index=0, size=0x1000.
- After reset with no writes, lookup ID 3 → rsp_valid at cycle 33, found=0, index=0, size=0.
- Slots 2 and 9 both written with ID 0x0042; slot 9 size 0x20 and slot 2 size 0x10; lookup 0x42 → found=1, index=2, size=0x10.
- Slot 5 has ID 0x0011 and size 0xABCD; lookup 0x11 with bridge_rd held high for 3 cycles starting at SCAN(idx5) → response delayed exactly 3 cycles, size=0xABCD. Bridge reads return correct data throughout.
- Write word 62 (slot 31) with ID 0x00FF; lookup 0x00FF → found=1, index=31. Word 62 upper bits set to 0xDEAD → still matches.
- Assert reset_n low during WAIT_ID → no rsp_valid. After release, req_ready=1 and a lookup of the previously written ID returns found=0.

Source files
------------

// File: rtl/bridge_dataslot_lookup_if.sv
// ---------------------------------------------------------------------------
// bridge_dataslot_lookup_if: bridge bus plus lookup request/response. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bridge_dataslot_lookup_if;
  logic [31:0] bridge_addr;
  logic        bridge_wr;
  logic        bridge_rd;
  logic [31:0] bridge_wr_data;
  logic [31:0] bridge_rd_data;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_id;
  logic        rsp_valid;
  logic        rsp_found;
  logic [4:0]  rsp_index;
  logic [31:0] rsp_size;

  modport slave (
    input  bridge_addr, bridge_wr, bridge_rd, bridge_wr_data, req_valid, req_id,
    output bridge_rd_data, req_ready, rsp_valid, rsp_found, rsp_index, rsp_size
  );

  modport master (
    output bridge_addr, bridge_wr, bridge_rd, bridge_wr_data, req_valid, req_id,
    input  bridge_rd_data, req_ready, rsp_valid, rsp_found, rsp_index, rsp_size
  );
endinterface

`default_nettype wire

// File: rtl/bridge_dataslot_lookup.sv
// ---------------------------------------------------------------------------
// bridge_dataslot_lookup: APF dataslot table with first-match ID scan. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bridge_dataslot_lookup #(
  parameter int NUM_SLOTS = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  bridge_dataslot_lookup_if.slave bus
);

  localparam int c_addr_w = $clog2(2 * NUM_SLOTS);
  localparam int c_idx_w  = $clog2(NUM_SLOTS);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SCAN      = 3'd1,
    S_WAIT_ID   = 3'd2,
    S_RD_SIZE   = 3'd3,
    S_WAIT_SIZE = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t               r_state, w_state_n;
  logic [c_idx_w-1:0]   r_idx, w_idx_n;
  logic [15:0]          r_id, w_id_n;
  logic                 r_found, w_found_n;
  logic [4:0]           r_index, w_index_n;
  logic [31:0]          r_size, w_size_n;
  logic [NUM_SLOTS-1:0] r_valid;
  logic [31:0]          r_mem [2*NUM_SLOTS];
  logic [31:0]          r_rd_data;

  logic                 w_bridge_active;
  logic [c_addr_w-1:0]  w_bridge_word;
  logic [c_addr_w-1:0]  w_fsm_word;
  logic [c_addr_w-1:0]  w_addr;
  logic                 w_last;
  logic                 w_unused;

  assign w_bridge_active = bus.bridge_wr | bus.bridge_rd;
  assign w_bridge_word   = bus.bridge_addr[c_addr_w+1:2];
  assign w_fsm_word      = {r_idx, (r_state == S_RD_SIZE)};
  assign w_addr          = w_bridge_active ? w_bridge_word : w_fsm_word;
  assign w_last          = (r_idx == c_last_idx);
  assign w_unused        = ^{bus.bridge_addr[31:c_addr_w+2], bus.bridge_addr[1:0]};

  // Table storage has no reset; only the shared read register does.
  always_ff @(posedge clk) begin
    if (bus.bridge_wr) begin
      r_mem[w_addr] <= bus.bridge_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
      r_valid   <= '0;
    end else begin
      r_rd_data <= r_mem[w_addr];
      if (bus.bridge_wr && !w_bridge_word[0]) begin
        r_valid[w_bridge_word[c_addr_w-1:1]] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_id    <= '0;
      r_found <= 1'b0;
      r_index <= '0;
      r_size  <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_id    <= w_id_n;
      r_found <= w_found_n;
      r_index <= w_index_n;
      r_size  <= w_size_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_id_n    = r_id;
    w_found_n = r_found;
    w_index_n = r_index;
    w_size_n  = r_size;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_id_n    = bus.req_id;
          w_idx_n   = '0;
          w_state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!w_bridge_active) begin
          if (r_valid[r_idx]) begin
            w_state_n = S_WAIT_ID;
          end else if (w_last) begin
            w_state_n = S_DONE;
            w_found_n = 1'b0;
            w_index_n = '0;
            w_size_n  = '0;
          end else begin
            w_idx_n = r_idx + c_idx_w'(1);
          end
        end
      end
      S_WAIT_ID: begin
        // Data register holds the ID word fetched during the previous cycle.
        if (r_rd_data[15:0] == r_id) begin
          w_state_n = S_RD_SIZE;
        end else if (w_last) begin
          w_state_n = S_DONE;
          w_found_n = 1'b0;
          w_index_n = '0;
          w_size_n  = '0;
        end else begin
          w_idx_n   = r_idx + c_idx_w'(1);
          w_state_n = S_SCAN;
        end
      end
      S_RD_SIZE: begin
        if (!w_bridge_active) begin
          w_state_n = S_WAIT_SIZE;
        end
      end
      S_WAIT_SIZE: begin
        w_size_n  = r_rd_data;
        w_found_n = 1'b1;
        w_index_n = 5'(r_idx);
        w_state_n = S_DONE;
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  assign bus.bridge_rd_data = r_rd_data;
  assign bus.req_ready      = (r_state == S_IDLE);
  assign bus.rsp_valid      = (r_state == S_DONE);
  assign bus.rsp_found      = r_found;
  assign bus.rsp_index      = r_index;
  assign bus.rsp_size       = r_size;

endmodule

`default_nettype wire

// File: tb/tb_bridge_dataslot_lookup.sv
// ---------------------------------------------------------------------------
// tb_bridge_dataslot_lookup: directed self-checking bench for the lookup. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bridge_dataslot_lookup;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bridge_dataslot_lookup_if bus ();

  bridge_dataslot_lookup #(.NUM_SLOTS(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic do_reset();
    reset_n            = 1'b0;
    bus.bridge_addr    = '0;
    bus.bridge_wr      = 1'b0;
    bus.bridge_rd      = 1'b0;
    bus.bridge_wr_data = '0;
    bus.req_valid      = 1'b0;
    bus.req_id         = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic bwrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.bridge_wr = 1'b1; bus.bridge_addr = addr; bus.bridge_wr_data = data;
    @(negedge clk);
    bus.bridge_wr = 1'b0;
  endtask

  task automatic bread(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.bridge_rd = 1'b1; bus.bridge_addr = addr;
    @(negedge clk);
    bus.bridge_rd = 1'b0;
    data = bus.bridge_rd_data;
  endtask

  // Latency is counted in cycles after the accepting edge (cycle 0).
  task automatic run_lookup(input logic [15:0] id, output int lat, output logic found,
                            output logic [4:0] idx, output logic [31:0] size,
                            output logic ready_after, output logic valid_after);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_id = id;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.rsp_valid) begin
        lat = n;
        break;
      end
    end
    found = bus.rsp_found; idx = bus.rsp_index; size = bus.rsp_size;
    @(negedge clk);
    ready_after = bus.req_ready; valid_after = bus.rsp_valid;
  endtask

  int          lat;
  logic        found, rdy, vld;
  logic [4:0]  idx;
  logic [31:0] size, rd;

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0h want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_found !== 1'b0) begin errors++; $display("FAIL reset_rsp_found: got %0h want 0", bus.rsp_found); end
    checks++; if (bus.rsp_index !== 5'd0) begin errors++; $display("FAIL reset_rsp_index: got %0h want 0", bus.rsp_index); end
    checks++; if (bus.rsp_size !== 32'd0) begin errors++; $display("FAIL reset_rsp_size: got %0h want 0", bus.rsp_size); end
    checks++; if (bus.bridge_rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data: got %0h want 0", bus.bridge_rd_data); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0h want 1", bus.req_ready); end
  endtask

  task automatic test_empty();
    run_lookup(16'h0003, lat, found, idx, size, rdy, vld);
    checks++; if (lat !== 33) begin errors++; $display("FAIL empty_latency: got %0d want 33", lat); end
    checks++; if (found !== 1'b0) begin errors++; $display("FAIL empty_found: got %0h want 0", found); end
    checks++; if (idx !== 5'd0 || size !== 32'd0) begin errors++; $display("FAIL empty_idx_size: got %0h/%0h want 0/0", idx, size); end
    checks++; if (rdy !== 1'b1 || vld !== 1'b0) begin errors++; $display("FAIL empty_after: ready/valid %0h/%0h want 1/0", rdy, vld); end
  endtask

  task automatic test_basic();
    bwrite(32'h0000_0000, 32'h0000_0007);
    bwrite(32'h0000_0004, 32'h0000_1000);
    bread(32'h0000_0004, rd);
    checks++; if (rd !== 32'h0000_1000) begin errors++; $display("FAIL basic_bridge_read: got %0h want 1000", rd); end
    run_lookup(16'h0007, lat, found, idx, size, rdy, vld);
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", lat); end
    checks++; if (found !== 1'b1 || idx !== 5'd0) begin errors++; $display("FAIL basic_found_idx: got %0h/%0h want 1/0", found, idx); end
    checks++; if (size !== 32'h0000_1000) begin errors++; $display("FAIL basic_size: got %0h want 1000", size); end
    checks++; if (rdy !== 1'b1 || vld !== 1'b0) begin errors++; $display("FAIL basic_after: ready/valid %0h/%0h want 1/0", rdy, vld); end
  endtask

  task automatic test_reset_mid_scan();
    bit seen = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_id = 16'h0007;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL midscan_in_reset: valid/ready %0h/%0h want 0/1", bus.rsp_valid, bus.req_ready); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midscan_no_rsp: got rsp_valid %0h want 0", seen); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midscan_ready: got %0h want 1", bus.req_ready); end
    run_lookup(16'h0007, lat, found, idx, size, rdy, vld);
    checks++; if (lat !== 33 || found !== 1'b0) begin errors++; $display("FAIL midscan_lookup: lat/found %0d/%0h want 33/0", lat, found); end
    bread(32'h0000_0004, rd);
    checks++; if (rd !== 32'h0000_1000) begin errors++; $display("FAIL midscan_ram_kept: got %0h want 1000", rd); end
  endtask

  task automatic test_duplicates();
    do_reset();
    bwrite(32'h0000_0010, 32'h0000_0042);
    bwrite(32'h0000_0014, 32'h0000_0010);
    bwrite(32'h1000_0048, 32'h0000_0042);
    bwrite(32'h0000_004C, 32'h0000_0020);
    run_lookup(16'h0042, lat, found, idx, size, rdy, vld);
    checks++; if (lat !== 7) begin errors++; $display("FAIL dup_latency: got %0d want 7", lat); end
    checks++; if (found !== 1'b1 || idx !== 5'd2) begin errors++; $display("FAIL dup_found_idx: got %0h/%0h want 1/2", found, idx); end
    checks++; if (size !== 32'h10) begin errors++; $display("FAIL dup_size: got %0h want 10", size); end
    run_lookup(16'h0043, lat, found, idx, size, rdy, vld);
    checks++; if (lat !== 35) begin errors++; $display("FAIL miss_latency: got %0d want 35", lat); end
    checks++; if (found !== 1'b0 || idx !== 5'd0 || size !== 32'd0) begin errors++; $display("FAIL miss_result: got %0h/%0h/%0h want 0/0/0", found, idx, size); end
  endtask

  task automatic test_bridge_stall();
    logic [31:0] exp_rd [3];
    logic [31:0] rd_addr [3];
    exp_rd  = '{32'h0000_0011, 32'h0000_ABCD, 32'h0000_0011};
    rd_addr = '{32'h28, 32'h2C, 32'h28};
    do_reset();
    bwrite(32'h0000_0028, 32'h0000_0011);
    bwrite(32'h0000_002C, 32'h0000_ABCD);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_id = 16'h0011;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (n >= 7 && n <= 9) begin
        checks++;
        if (bus.bridge_rd_data !== exp_rd[n-7]) begin
          errors++; $display("FAIL stall_bridge_read%0d: got %0h want %0h", n - 7, bus.bridge_rd_data, exp_rd[n-7]);
        end
      end
      if (bus.rsp_valid) begin
        lat = n;
        break;
      end
      bus.bridge_rd   = (n >= 6 && n <= 8);
      bus.bridge_addr = (n >= 6 && n <= 8) ? rd_addr[n-6] : 32'h0;
    end
    bus.bridge_rd = 1'b0;
    checks++; if (lat !== 13) begin errors++; $display("FAIL stall_latency: got %0d want 13", lat); end
    checks++; if (bus.rsp_found !== 1'b1 || bus.rsp_index !== 5'd5) begin errors++; $display("FAIL stall_found_idx: got %0h/%0h want 1/5", bus.rsp_found, bus.rsp_index); end
    checks++; if (bus.rsp_size !== 32'h0000_ABCD) begin errors++; $display("FAIL stall_size: got %0h want abcd", bus.rsp_size); end
  endtask

  task automatic test_last_slot();
    do_reset();
    bwrite(32'h0000_00F8, 32'h0000_00FF);
    bwrite(32'h0000_00FC, 32'h0000_0031);
    run_lookup(16'h00FF, lat, found, idx, size, rdy, vld);
    checks++; if (lat !== 36) begin errors++; $display("FAIL last_latency: got %0d want 36", lat); end
    checks++; if (found !== 1'b1 || idx !== 5'd31 || size !== 32'h31) begin errors++; $display("FAIL last_result: got %0h/%0h/%0h want 1/1f/31", found, idx, size); end
    bwrite(32'h0000_00F8, 32'hDEAD_00FF);
    bread(32'h0000_00F8, rd);
    checks++; if (rd !== 32'hDEAD_00FF) begin errors++; $display("FAIL last_readback: got %0h want dead00ff", rd); end
    run_lookup(16'h00FF, lat, found, idx, size, rdy, vld);
    checks++; if (lat !== 36 || found !== 1'b1 || idx !== 5'd31) begin errors++; $display("FAIL last_upper_bits: lat/found/idx %0d/%0h/%0h want 36/1/1f", lat, found, idx); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_basic();
    test_reset_mid_scan();
    test_duplicates();
    test_bridge_stall();
    test_last_slot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
